// File: rtl/multi_sine_reader.sv
// multi_sine_reader: multi-channel quarter-wave sine oscillator bank.
// One shared synchronous ROM, time-multiplexed; saturated channel mix.
module multi_sine_reader #(
  parameter int CHANNELS = 2,
  parameter int PHASE_W  = 20,
  parameter int ADDR_W   = 8,
  parameter int SAMPLE_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*PHASE_W-1:0]  step_size,
  input  logic [CHANNELS-1:0]          chan_en,
  input  logic                         phase_clear,
  input  logic                         generate_next,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [SAMPLE_W-2:0]          rom_data,
  output logic                         busy,
  output logic                         sample_ready,
  output logic [CHANNELS*SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0]          mix
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W = SAMPLE_W + $clog2(CHANNELS) + 1;
  localparam logic [CH_W-1:0] LAST = CH_W'(CHANNELS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI =
    ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_STORE, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CH_W-1:0]              r_ch;
  logic [PHASE_W-1:0]           r_phase [CHANNELS];
  logic [ADDR_W-1:0]            r_rom_addr;
  logic [CHANNELS*SAMPLE_W-1:0] r_sample;
  logic [SAMPLE_W-1:0]          r_mix;
  logic signed [ACC_W-1:0]      r_acc;

  logic [1:0]                   w_quad;
  logic [ADDR_W-1:0]            w_idx;
  logic                         w_en;
  logic [PHASE_W-1:0]           w_step;
  logic [SAMPLE_W-1:0]          w_mag;
  logic signed [SAMPLE_W-1:0]   w_samp;
  logic signed [ACC_W-1:0]      w_ext;
  logic signed [ACC_W-1:0]      w_acc_next;
  logic [SAMPLE_W-1:0]          w_sat;
  logic                         w_busy;
  logic                         w_ready;

  assign w_quad = r_phase[r_ch][PHASE_W-1 -: 2];
  assign w_idx  = r_phase[r_ch][PHASE_W-3 -: ADDR_W];
  assign w_en   = chan_en[r_ch];
  assign w_step = step_size[r_ch*PHASE_W +: PHASE_W];
  assign w_mag  = {1'b0, rom_data};
  assign w_ext  = {{(ACC_W-SAMPLE_W){w_samp[SAMPLE_W-1]}}, w_samp};
  assign w_acc_next = r_acc + w_ext;

  // Signed channel sample: quadrants 2/3 negate the ROM magnitude.
  always_comb begin
    w_samp = '0;
    if (w_en) begin
      w_samp = w_quad[1] ? -w_mag : w_mag;
    end
  end

  // Clamp the running sum into the signed sample range.
  always_comb begin
    w_sat = w_acc_next[SAMPLE_W-1:0];
    if (w_acc_next > SAT_HI) begin
      w_sat = SAT_HI[SAMPLE_W-1:0];
    end else if (w_acc_next < SAT_LO) begin
      w_sat = SAT_LO[SAMPLE_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a phase clear always lands in IDLE.
  always_comb begin
    w_next = r_state;
    if (phase_clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (generate_next) w_next = S_ADDR;
        S_ADDR:  w_next = S_DATA;
        S_DATA:  w_next = S_STORE;
        S_STORE: w_next = (r_ch == LAST) ? S_DONE : S_ADDR;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the state.
  always_comb begin
    w_busy  = (r_state != S_IDLE);
    w_ready = (r_state == S_DONE);
  end

  // Datapath: ROM address, per-channel store, phase advance, mix.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ch       <= '0;
      r_rom_addr <= '0;
      r_sample   <= '0;
      r_mix      <= '0;
      r_acc      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_phase[i] <= '0;
      end
    end else if (phase_clear) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_phase[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (generate_next) begin
            r_ch  <= '0;
            r_acc <= '0;
          end
        end
        S_ADDR: begin
          r_rom_addr <= w_quad[0] ? ~w_idx : w_idx;
        end
        S_STORE: begin
          r_sample[r_ch*SAMPLE_W +: SAMPLE_W] <= w_samp;
          if (w_en) begin
            r_phase[r_ch] <= r_phase[r_ch] + w_step;
          end
          r_acc <= w_acc_next;
          if (r_ch == LAST) begin
            r_mix <= w_sat;
          end else begin
            r_ch <= r_ch + CH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr     = r_rom_addr;
  assign sample       = r_sample;
  assign mix          = r_mix;
  assign busy         = w_busy;
  assign sample_ready = w_ready;

endmodule

// File: tb/tb_multi_sine_reader.sv
// tb_multi_sine_reader: directed bench for multi_sine_reader (2 channels).
// Synchronous ROM model: identity (data = addr) or constant 32767.
module tb_multi_sine_reader;

  localparam int CH = 2;
  localparam int PW = 20;
  localparam int AW = 8;
  localparam int SW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH*PW-1:0] step_size;
  logic [CH-1:0]   chan_en;
  logic            phase_clear;
  logic            generate_next;
  logic [AW-1:0]   rom_addr;
  logic [SW-2:0]   rom_data;
  logic            busy;
  logic            sample_ready;
  logic [CH*SW-1:0] sample;
  logic [SW-1:0]   mix;

  bit rom_const;
  int total;
  int bad;

  multi_sine_reader #(
    .CHANNELS(CH), .PHASE_W(PW), .ADDR_W(AW), .SAMPLE_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .step_size(step_size),
    .chan_en(chan_en), .phase_clear(phase_clear),
    .generate_next(generate_next), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy), .sample_ready(sample_ready),
    .sample(sample), .mix(mix)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data <= rom_const ? 15'h7fff : {7'd0, rom_addr};
  end

  task automatic set_steps(input logic [PW-1:0] s0,
                           input logic [PW-1:0] s1);
    step_size = {s1, s0};
  endtask

  task automatic clear_phase();
    @(negedge clk);
    phase_clear = 1'b1;
    @(negedge clk);
    phase_clear = 1'b0;
  endtask

  task automatic run_frame(output int lat);
    @(negedge clk);
    generate_next = 1'b1;
    @(posedge clk);
    #1 generate_next = 1'b0;
    lat = 0;
    while (!sample_ready && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    total++;
    if (sample_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready: got %b want 0", sample_ready);
    end
    total++;
    if (sample !== '0) begin
      bad++; $display("FAIL rst_sample: got %h want 0", sample);
    end
    total++;
    if (mix !== '0) begin
      bad++; $display("FAIL rst_mix: got %h want 0", mix);
    end
    total++;
    if (rom_addr !== '0) begin
      bad++; $display("FAIL rst_addr: got %h want 0", rom_addr);
    end
  endtask

  task automatic test_addressing();
    int e[9] = '{0, 128, 255, 127, 0, -128, -255, -127, 0};
    int lat;
    chan_en = 2'b01;
    set_steps(20'h20000, 20'h0);
    for (int i = 0; i < 9; i++) begin
      run_frame(lat);
      total++;
      if (sample[15:0] !== 16'(e[i])) begin
        bad++;
        $display("FAIL addr_ch0[%0d]: got %0d want %0d",
                 i, $signed(sample[15:0]), e[i]);
      end
      total++;
      if (mix !== 16'(e[i])) begin
        bad++;
        $display("FAIL addr_mix[%0d]: got %0d want %0d",
                 i, $signed(mix), e[i]);
      end
    end
    total++;
    if (sample[31:16] !== 16'd0) begin
      bad++;
      $display("FAIL addr_ch1_off: got %0d want 0",
               $signed(sample[31:16]));
    end
  endtask

  task automatic test_latency();
    int lat;
    int first;
    int second;
    int hi;
    int idle_cnt;
    clear_phase();
    chan_en = 2'b11;
    set_steps(20'h20000, 20'h40000);
    run_frame(lat);
    total++;
    if (lat !== 6) begin
      bad++; $display("FAIL latency: got %0d want 6", lat);
    end
    first = -1;
    second = -1;
    hi = 0;
    idle_cnt = 0;
    @(negedge clk);
    generate_next = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (sample_ready) begin
        hi++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (first >= 0 && second < 0 && !busy) idle_cnt++;
    end
    generate_next = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    total++;
    if (first !== 6) begin
      bad++; $display("FAIL held_first: got %0d want 6", first);
    end
    total++;
    if (second - first !== 8) begin
      bad++;
      $display("FAIL held_period: got %0d want 8", second - first);
    end
    total++;
    if (hi !== 3) begin
      bad++; $display("FAIL held_pulses: got %0d want 3", hi);
    end
    total++;
    if (idle_cnt !== 1) begin
      bad++; $display("FAIL held_idle: got %0d want 1", idle_cnt);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL drain_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_independence();
    int e0[4] = '{0, 128, 255, 127};
    int e1[4] = '{0, 255, 0, -255};
    int lat;
    clear_phase();
    chan_en = 2'b11;
    set_steps(20'h20000, 20'h40000);
    for (int i = 0; i < 4; i++) begin
      run_frame(lat);
      total++;
      if (sample[15:0] !== 16'(e0[i])) begin
        bad++;
        $display("FAIL ind_ch0[%0d]: got %0d want %0d",
                 i, $signed(sample[15:0]), e0[i]);
      end
      total++;
      if (sample[31:16] !== 16'(e1[i])) begin
        bad++;
        $display("FAIL ind_ch1[%0d]: got %0d want %0d",
                 i, $signed(sample[31:16]), e1[i]);
      end
      total++;
      if (mix !== 16'(e0[i] + e1[i])) begin
        bad++;
        $display("FAIL ind_mix[%0d]: got %0d want %0d",
                 i, $signed(mix), e0[i] + e1[i]);
      end
    end
  endtask

  task automatic test_disable();
    logic [1:0] en[3] = '{2'b11, 2'b01, 2'b11};
    int e1[3] = '{0, 0, 255};
    int lat;
    clear_phase();
    set_steps(20'h20000, 20'h40000);
    for (int i = 0; i < 3; i++) begin
      chan_en = en[i];
      run_frame(lat);
      total++;
      if (sample[31:16] !== 16'(e1[i])) begin
        bad++;
        $display("FAIL dis_ch1[%0d]: got %0d want %0d",
                 i, $signed(sample[31:16]), e1[i]);
      end
    end
    total++;
    if (sample[15:0] !== 16'd255) begin
      bad++;
      $display("FAIL dis_ch0: got %0d want 255",
               $signed(sample[15:0]));
    end
  endtask

  task automatic test_saturation();
    int lat;
    rom_const = 1'b1;
    chan_en = 2'b11;
    clear_phase();
    set_steps(20'h80000, 20'h80000);
    run_frame(lat);
    total++;
    if (mix !== 16'h7fff) begin
      bad++; $display("FAIL sat_hi: got %h want 7fff", mix);
    end
    run_frame(lat);
    total++;
    if (mix !== 16'h8000) begin
      bad++; $display("FAIL sat_lo: got %h want 8000", mix);
    end
    total++;
    if (sample !== {16'h8001, 16'h8001}) begin
      bad++; $display("FAIL sat_samp: got %h want 80018001", sample);
    end
    clear_phase();
    set_steps(20'h0, 20'h80000);
    run_frame(lat);
    run_frame(lat);
    total++;
    if (mix !== 16'h0000) begin
      bad++; $display("FAIL sat_cancel: got %h want 0000", mix);
    end
    rom_const = 1'b0;
  endtask

  task automatic test_abort();
    int lat;
    int pulses;
    clear_phase();
    chan_en = 2'b11;
    set_steps(20'h20000, 20'h40000);
    run_frame(lat);
    run_frame(lat);
    @(negedge clk);
    generate_next = 1'b1;
    @(posedge clk);
    #1 generate_next = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    phase_clear = 1'b1;
    @(posedge clk);
    #1 phase_clear = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL abort_busy: got %b want 0", busy);
    end
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (sample_ready) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++; $display("FAIL abort_ready: got %0d want 0", pulses);
    end
    total++;
    if (sample !== {16'd255, 16'd255}) begin
      bad++; $display("FAIL abort_keep: got %h want 00ff00ff", sample);
    end
    total++;
    if (mix !== 16'd383) begin
      bad++; $display("FAIL abort_mix: got %0d want 383", mix);
    end
    run_frame(lat);
    total++;
    if (sample !== '0) begin
      bad++; $display("FAIL abort_next: got %h want 0", sample);
    end
    @(negedge clk);
    generate_next = 1'b1;
    @(posedge clk);
    #1 generate_next = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) generate_next = 1'b1;
      if (c == 3) generate_next = 1'b0;
      if (sample_ready) pulses++;
    end
    total++;
    if (pulses !== 1) begin
      bad++; $display("FAIL busy_ignore: got %0d want 1", pulses);
    end
    @(negedge clk);
    generate_next = 1'b1;
    phase_clear = 1'b1;
    @(posedge clk);
    #1;
    generate_next = 1'b0;
    phase_clear = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL clear_wins: got %b want 0", busy);
    end
  endtask

  task automatic test_reset_midframe();
    int lat;
    clear_phase();
    chan_en = 2'b11;
    set_steps(20'h20000, 20'h40000);
    run_frame(lat);
    run_frame(lat);
    @(negedge clk);
    generate_next = 1'b1;
    @(posedge clk);
    #1 generate_next = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    total++;
    if ({sample, mix, rom_addr} !== '0) begin
      bad++;
      $display("FAIL rmid_data: got %h/%h/%h want 0",
               sample, mix, rom_addr);
    end
    total++;
    if ({busy, sample_ready} !== 2'b00) begin
      bad++;
      $display("FAIL rmid_ctrl: got %b%b want 00", busy, sample_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    run_frame(lat);
    total++;
    if (lat !== 6 || sample !== '0) begin
      bad++;
      $display("FAIL rmid_f1: got lat=%0d %h want lat=6 0", lat, sample);
    end
    run_frame(lat);
    total++;
    if (sample !== {16'd255, 16'd128}) begin
      bad++; $display("FAIL rmid_f2: got %h want 00ff0080", sample);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rom_const = 1'b0;
    reset = 1'b0;
    step_size = '0;
    chan_en = '0;
    phase_clear = 1'b0;
    generate_next = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    test_reset();
    test_addressing();
    test_latency();
    test_independence();
    test_disable();
    test_saturation();
    test_abort();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
